change_dispenser: RTL and testbench



---
 rtl/vending_pkg.sv | 31 +++
 rtl/change_dispenser_denom_picker.sv | 35 +++
 rtl/change_dispenser.sv | 122 ++++++++++++
 tb/tb_change_dispenser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: denominations, coin_sel one-hot codes and the
// one-hot state encoding used by the change dispenser.
package vending_pkg;

  localparam int MONEY_W_DEF = 8;

  // Denominations, identical to the payment-accumulation values.
  localparam int DENOM_1  = 1;
  localparam int DENOM_5  = 5;
  localparam int DENOM_10 = 10;
  localparam int DENOM_20 = 20;
  localparam int DENOM_50 = 50;

  // One-hot coin_sel encodings.
  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_1    = 5'b00001;
  localparam logic [4:0] SEL_5    = 5'b00010;
  localparam logic [4:0] SEL_10   = 5'b00100;
  localparam logic [4:0] SEL_20   = 5'b01000;
  localparam logic [4:0] SEL_50   = 5'b10000;

  // Change dispenser states, one-hot like the vending machine states.
  typedef enum logic [4:0] {
    CD_IDLE   = 5'b00001,
    CD_SELECT = 5'b00010,
    CD_REQ    = 5'b00100,
    CD_GAP    = 5'b01000,
    CD_DONE   = 5'b10000
  } cd_state_e;

endpackage

// File: rtl/change_dispenser_denom_picker.sv
// Greedy denomination picker: largest note not exceeding the balance.
// Returns no selection and a zero value when the balance is zero.
module denom_picker
  import vending_pkg::*;
#(
  parameter int MONEY_W = MONEY_W_DEF
) (
  input  logic [MONEY_W-1:0] remaining_i,
  output logic [4:0]         sel_o,
  output logic [MONEY_W-1:0] denom_o
);

  // Priority compare from the largest denomination down.
  always_comb begin
    sel_o   = SEL_NONE;
    denom_o = '0;
    if (remaining_i >= MONEY_W'(DENOM_50)) begin
      sel_o   = SEL_50;
      denom_o = MONEY_W'(DENOM_50);
    end else if (remaining_i >= MONEY_W'(DENOM_20)) begin
      sel_o   = SEL_20;
      denom_o = MONEY_W'(DENOM_20);
    end else if (remaining_i >= MONEY_W'(DENOM_10)) begin
      sel_o   = SEL_10;
      denom_o = MONEY_W'(DENOM_10);
    end else if (remaining_i >= MONEY_W'(DENOM_5)) begin
      sel_o   = SEL_5;
      denom_o = MONEY_W'(DENOM_5);
    end else if (remaining_i >= MONEY_W'(DENOM_1)) begin
      sel_o   = SEL_1;
      denom_o = MONEY_W'(DENOM_1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: splits a change amount into notes greedily and issues
// them one at a time over a req/ack handshake to the hopper. All outputs
// are registered; reset aborts any dispense in progress.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int MONEY_W    = MONEY_W_DEF,
  parameter int GAP_CYCLES = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [MONEY_W-1:0] change_amount,
  input  logic               coin_ack,
  output logic               coin_req,
  output logic [4:0]         coin_sel,
  output logic [MONEY_W-1:0] remaining,
  output logic [MONEY_W-1:0] coin_count,
  output logic               busy,
  output logic               done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  cd_state_e          state_q;
  logic               coin_req_q;
  logic [4:0]         coin_sel_q;
  logic [MONEY_W-1:0] remaining_q;
  logic [MONEY_W-1:0] count_q;
  logic               busy_q;
  logic               done_q;
  logic [GAP_W-1:0]   gap_cnt_q;

  logic [4:0]         pick_sel;
  logic [MONEY_W-1:0] pick_denom;
  logic [MONEY_W-1:0] remaining_d;
  logic [MONEY_W-1:0] count_d;

  // Issued-note counter sticks at all-ones instead of wrapping.
  function automatic logic [MONEY_W-1:0] sat_inc(input logic [MONEY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  denom_picker #(.MONEY_W(MONEY_W)) u_picker (
    .remaining_i (remaining_q),
    .sel_o       (pick_sel),
    .denom_o     (pick_denom)
  );

  // Balance is stable throughout REQ, so the picker still reflects the note in flight.
  assign remaining_d = remaining_q - pick_denom;
  assign count_d     = sat_inc(count_q);

  // Dispense FSM with registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= CD_IDLE;
      coin_req_q  <= 1'b0;
      coin_sel_q  <= SEL_NONE;
      remaining_q <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CD_IDLE: begin
          if (start) begin
            remaining_q <= change_amount;
            count_q     <= '0;
            busy_q      <= 1'b1;
            state_q     <= CD_SELECT;
          end
        end
        CD_SELECT: begin
          if (remaining_q == '0) begin
            done_q  <= 1'b1;
            state_q <= CD_DONE;
          end else begin
            coin_sel_q <= pick_sel;
            coin_req_q <= 1'b1;
            state_q    <= CD_REQ;
          end
        end
        CD_REQ: begin
          if (coin_ack) begin
            coin_req_q  <= 1'b0;
            coin_sel_q  <= SEL_NONE;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            gap_cnt_q   <= '0;
            state_q     <= (GAP_CYCLES > 0) ? CD_GAP : CD_SELECT;
          end
        end
        CD_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_q <= CD_SELECT;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        CD_DONE: begin
          busy_q  <= 1'b0;
          state_q <= CD_IDLE;
        end
        default: begin
          coin_req_q <= 1'b0;
          coin_sel_q <= SEL_NONE;
          busy_q     <= 1'b0;
          state_q    <= CD_IDLE;
        end
      endcase
    end
  end

  assign coin_req   = coin_req_q;
  assign coin_sel   = coin_sel_q;
  assign remaining  = remaining_q;
  assign coin_count = count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy reference model queues the
// expected notes and completion counts; a negedge monitor checks them.
module tb_change_dispenser;

  localparam int MW  = 8;
  localparam int GAP = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] change_amount = '0;
  logic          coin_ack = 1'b0;
  logic          coin_req;
  logic [4:0]    coin_sel;
  logic [MW-1:0] remaining;
  logic [MW-1:0] coin_count;
  logic          busy;
  logic          done;

  change_dispenser #(.MONEY_W(MW), .GAP_CYCLES(GAP)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .change_amount (change_amount),
    .coin_ack      (coin_ack),
    .coin_req      (coin_req),
    .coin_sel      (coin_sel),
    .remaining     (remaining),
    .coin_count    (coin_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int val; int cnt; } note_t;

  int    den[5] = '{1, 5, 10, 20, 50};
  note_t exp_note[$];
  int    exp_done[$];
  int    rem_model = 0;
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    cyc = 0;
  int    last_rise = -100;
  bit    prev_req = 1'b0;
  bit    chk_idle_next = 1'b0;
  int    ack_delay = 0;
  bit    ack_hold = 1'b0;
  int    hop_cnt = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int sel_of(input int val);
    for (int k = 0; k < 5; k++) if (den[k] == val) return (1 << k);
    return 0;
  endfunction

  // Reference model: greedy change breakdown from the denomination list.
  task automatic model_push(input int amt);
    int a = amt;
    int c = 0;
    note_t n;
    while (a > 0) begin
      for (int k = 4; k >= 0; k--) begin
        if (den[k] <= a) begin
          n.val = den[k];
          n.cnt = c;
          exp_note.push_back(n);
          a -= den[k];
          c++;
          break;
        end
      end
    end
    exp_done.push_back(c);
  endtask

  task automatic do_start(input int amt);
    @(negedge sys_clk);
    model_push(amt);
    rem_model     = amt;
    change_amount = MW'(amt);
    start         = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    @(negedge sys_clk);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!coin_req && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (!coin_req) check("req_timeout", 0, 1);
  endtask

  // Hopper model: acknowledges after ack_delay cycles, or holds ack high.
  always @(posedge sys_clk) begin
    #2;
    if (ack_hold) coin_ack = 1'b1;
    else if (coin_req && !coin_ack) begin
      if (hop_cnt >= ack_delay) begin
        coin_ack = 1'b1;
        hop_cnt  = 0;
      end else hop_cnt++;
    end else if (coin_ack) coin_ack = 1'b0;
  end

  // Monitor: compares DUT outputs with the scoreboard between clock edges.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst_n) begin
      if (chk_idle_next) begin
        check("busy_after_done", busy, 0);
        chk_idle_next = 1'b0;
      end
      if (!coin_req) check("sel_zero_idle", coin_sel, 0);
      if (coin_req) begin
        if (!prev_req) begin
          if (last_rise >= 0) begin
            checks++;
            if (cyc - last_rise < GAP + 2) begin
              errors++;
              $display("FAIL req_spacing: got %0d cycles expected >= %0d", cyc - last_rise, GAP + 2);
            end
          end
          last_rise = cyc;
        end
        if (exp_note.size() == 0) check("unexpected_req", 1, 0);
        else begin
          check("coin_sel", coin_sel, sel_of(exp_note[0].val));
          check("count_before_note", coin_count, exp_note[0].cnt);
          if (coin_ack) begin
            rem_model -= exp_note[0].val;
            void'(exp_note.pop_front());
          end
        end
      end
      if (busy && !(coin_req && coin_ack)) check("remaining", remaining, rem_model);
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 1);
        check("remaining_at_done", remaining, 0);
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("coin_count_at_done", coin_count, exp_done.pop_front());
        chk_idle_next = 1'b1;
      end
    end
    prev_req = coin_req;
  end

  initial begin
    int amt;
    // Reset state
    #2;
    check("rst_coin_req", coin_req, 0);
    check("rst_coin_sel", coin_sel, 0);
    check("rst_remaining", remaining, 0);
    check("rst_coin_count", coin_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Amount 37, prompt acks
    ack_delay = 0;
    do_start(37);
    check("busy_after_start", busy, 1);
    wait_done(500);

    // Amount 0: done two cycles after start, no request
    do_start(0);
    check("zero_no_done_early", done, 0);
    @(negedge sys_clk);
    check("zero_done_timing", done, 1);
    @(negedge sys_clk);
    check("zero_done_pulse", done, 0);
    check("zero_busy_low", busy, 0);
    check("zero_count", coin_count, 0);

    // Amount 255
    do_start(255);
    wait_done(1000);

    // Amount 12 with the first ack withheld
    ack_delay = 10;
    do_start(12);
    wait_req(20);
    repeat (5) @(negedge sys_clk);
    ack_delay = 0;
    wait_done(500);

    // Second start while busy is ignored
    do_start(8);
    wait_req(20);
    @(negedge sys_clk);
    change_amount = MW'(99);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(500);

    // Ack held high continuously
    ack_hold = 1'b1;
    do_start(37);
    wait_done(500);
    ack_hold = 1'b0;
    @(posedge sys_clk);
    #3 coin_ack = 1'b0;

    // Asynchronous reset mid-dispense
    ack_delay = 50;
    do_start(70);
    wait_req(20);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_coin_req", coin_req, 0);
    check("arst_remaining", remaining, 0);
    check("arst_busy", busy, 0);
    check("arst_coin_count", coin_count, 0);
    exp_note.delete();
    exp_done.delete();
    coin_ack = 1'b0;
    hop_cnt = 0;
    last_rise = -100;
    ack_delay = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    do_start(6);
    wait_done(500);

    // Random amounts and ack latencies
    for (int i = 0; i < 20; i++) begin
      amt = int'($urandom_range(0, 255));
      ack_delay = int'($urandom_range(0, 3));
      do_start(amt);
      wait_done(2000);
    end

    repeat (3) @(negedge sys_clk);
    check("notes_left", exp_note.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
